// File: rtl/teclado_irq_pkg.sv
// Shared scan-code and key-code constants, frame state encoding and the
// make-code to key-code lookup used by the keyboard interrupt block.
package teclado_irq_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  localparam logic [7:0] KEY_W = 8'h57;
  localparam logic [7:0] KEY_S = 8'h53;
  localparam logic [7:0] KEY_A = 8'h65;
  localparam logic [7:0] KEY_D = 8'h68;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef struct packed {
    logic       hit;
    logic [7:0] code;
  } key_map_t;

  function automatic key_map_t map_scan(input logic [7:0] sc);
    key_map_t km;
    km.hit  = 1'b1;
    km.code = 8'h00;
    case (sc)
      SC_W:    km.code = KEY_W;
      SC_S:    km.code = KEY_S;
      SC_A:    km.code = KEY_A;
      SC_D:    km.code = KEY_D;
      default: km.hit  = 1'b0;
    endcase
    return km;
  endfunction

endpackage

// File: rtl/teclado_irq_ps2_rx_frame.sv
// PS/2 receiver: synchronizes and filters the keyboard clock, shifts an
// 11-bit frame on filtered falling edges and checks odd parity and stop bit.
module ps2_rx_frame
  import teclado_irq_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_fall;
  logic          strobe;
  logic          d_bit;
  logic [1:0]    state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [9:0]    shreg;
  logic          frame_ok;

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample
  assign filt_fall = (c_s2 != filt) && (filt_cnt == FW'(FILTER_LEN - 1)) && !c_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_s1     <= 1'b1;
      c_s2     <= 1'b1;
      d_s1     <= 1'b1;
      d_s2     <= 1'b1;
      filt     <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      c_s1   <= ps2c;
      c_s2   <= c_s1;
      d_s1   <= ps2d;
      d_s2   <= d_s1;
      strobe <= filt_fall;
      if (c_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= c_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (filt_fall) d_bit <= d_s2;
    if (state == ST_SHIFT && strobe) shreg <= {d_bit, shreg[9:1]};
  end

  // shreg holds {stop, parity, data[7:0]} once ten bits follow the start bit
  assign frame_ok   = (^shreg[8:0]) & shreg[9];
  assign byte_valid = (state == ST_CHECK) && frame_ok;
  assign rx_byte    = shreg[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strobe && !d_bit) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            tmo_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (strobe) begin
            tmo_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd9) state <= ST_CHECK;
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            frame_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          state     <= ST_IDLE;
          frame_err <= ~frame_ok;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/teclado_irq.sv
// Keyboard interrupt source: drops break/extended sequences, maps W/S/A/D
// make codes to key codes and runs the request/acknowledge handshake.
module teclado_irq
  import teclado_irq_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       interrupt_ack,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic       overflow,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       brk_flag, ext_flag;
  logic       is_prefix;
  logic       key_ev;
  key_map_t   km;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign km        = map_scan(rx_byte);
  assign is_prefix = (rx_byte == SC_BREAK) || (rx_byte == SC_EXT);
  assign key_ev    = byte_valid && !is_prefix && !brk_flag && !ext_flag && km.hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_flag  <= 1'b0;
      ext_flag  <= 1'b0;
      in_port   <= 8'h00;
      interrupt <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // A prefix keeps any earlier flag so E0 F0 xx swallows xx as well
      if (byte_valid) begin
        if (rx_byte == SC_BREAK) begin
          brk_flag <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext_flag <= 1'b1;
        end else begin
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
        end
      end
      if (key_ev && (!interrupt || interrupt_ack)) begin
        in_port   <= km.code;
        interrupt <= 1'b1;
      end else begin
        if (key_ev) overflow <= 1'b1;
        if (interrupt_ack) interrupt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_teclado_irq.sv
// Self-checking bench for teclado_irq: directed scenarios plus random frames
// compared every idle cycle against a frame-level behavioural model.
module tb_teclado_irq;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int LOW  = 10;
  localparam int HIGH = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c, ps2d, interrupt_ack;
  logic [7:0] in_port;
  logic       interrupt, overflow, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  bit chk_en   = 1'b0;

  logic [7:0] m_in;
  bit         m_int, m_ovf, m_brk, m_ext;
  logic [7:0] keymap [logic [7:0]];

  teclado_irq #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .interrupt_ack(interrupt_ack),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (chk_en) begin
      check("in_port", {24'd0, in_port}, {24'd0, m_in});
      check("interrupt", {31'd0, interrupt}, {31'd0, m_int});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("frame_err_quiet", {31'd0, frame_err}, 32'd0);
    end
  end

  task automatic model_reset();
    m_in = 8'h00; m_int = 0; m_ovf = 0; m_brk = 0; m_ext = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good, input bit ack_same);
    if (!good) return;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk || m_ext) begin
      m_brk = 0; m_ext = 0;
    end else if (keymap.exists(b)) begin
      if (m_int && !ack_same) m_ovf = 1;
      else begin
        m_in = keymap[b]; m_int = 1;
      end
    end
  endtask

  // mode 1: check the request rises exactly one clock after the check cycle
  // mode 2: pulse the acknowledge on the very cycle the byte is accepted
  task automatic ps2_bit(input bit v, input int mode, input bit last);
    ps2d = v;
    repeat (HIGH / 2) @(negedge clk);
    ps2c = 1'b0;
    for (int i = 1; i <= LOW; i++) begin
      @(negedge clk);
      if (last && mode == 1 && i == 3 + FL) check("irq_before_latency", {31'd0, interrupt}, 32'd0);
      if (last && mode == 1 && i == 4 + FL) check("irq_latency_1clk", {31'd0, interrupt}, 32'd1);
      if (last && mode == 2 && i == 3 + FL) interrupt_ack = 1'b1;
      if (last && mode == 2 && i == 4 + FL) interrupt_ack = 1'b0;
    end
    ps2c = 1'b1;
    repeat (HIGH / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok, input int mode);
    logic [10:0] bits;
    chk_en   = 0;
    ferr_cnt = 0;
    bits = {stop_ok, (~^b) ^ !par_ok, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], mode, i == 10);
    repeat (2) @(negedge clk);
    model_frame(b, par_ok && stop_ok, mode == 2);
    check("frame_err_count", ferr_cnt, (par_ok && stop_ok) ? 32'd0 : 32'd1);
    chk_en = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    logic [10:0] bits;
    chk_en = 0;
    bits = {2'b11, b, 1'b0};
    for (int i = 0; i < n; i++) ps2_bit(bits[i], 0, 1'b0);
  endtask

  task automatic do_ack();
    chk_en = 0;
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    m_int = 0;
    chk_en = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pick [7];
    logic [7:0] b;
    int r;
    keymap[8'h1D] = 8'h57;
    keymap[8'h1B] = 8'h53;
    keymap[8'h1C] = 8'h65;
    keymap[8'h23] = 8'h68;
    pick = '{8'hF0, 8'hE0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h00};
    ps2c = 1'b1; ps2d = 1'b1; interrupt_ack = 1'b0; reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_port", {24'd0, in_port}, 32'h00);
    check("rst_interrupt", {31'd0, interrupt}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'h1D, 1, 1, 1);
    check("w_code", {24'd0, in_port}, 32'h57);
    check("w_model", {24'd0, m_in}, 32'h57);
    do_ack();
    check("ack_irq_low", {31'd0, interrupt}, 32'd0);
    check("ack_in_kept", {24'd0, in_port}, 32'h57);

    send_frame(8'hF0, 1, 1, 0);
    send_frame(8'h1D, 1, 1, 0);
    send_frame(8'hE0, 1, 1, 0);
    send_frame(8'h1C, 1, 1, 0);
    send_frame(8'hE0, 1, 1, 0);
    send_frame(8'hF0, 1, 1, 0);
    send_frame(8'h1B, 1, 1, 0);
    check("prefix_no_irq", {31'd0, interrupt}, 32'd0);
    send_frame(8'h23, 1, 1, 0);
    check("d_code", {24'd0, in_port}, 32'h68);
    do_ack();

    send_frame(8'h1B, 0, 1, 0);
    send_frame(8'h1B, 1, 0, 0);
    check("bad_frame_no_irq", {31'd0, interrupt}, 32'd0);

    send_frame(8'h1D, 1, 1, 0);
    send_frame(8'h1B, 1, 1, 0);
    check("ovf_in_kept", {24'd0, in_port}, 32'h57);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    send_frame(8'h1C, 1, 1, 2);
    check("ack_same_code", {24'd0, in_port}, 32'h65);
    check("ack_same_irq", {31'd0, interrupt}, 32'd1);
    do_ack();

    send_partial(8'h23, 5);
    ferr_cnt = 0;
    repeat (TO + 60) @(negedge clk);
    check("timeout_frame_err", ferr_cnt, 32'd1);
    send_frame(8'h23, 1, 1, 0);
    check("after_timeout", {24'd0, in_port}, 32'h68);
    do_ack();

    chk_en = 0;
    ps2d = 1'b0;
    ps2c = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2c = 1'b1;
    repeat (20) @(negedge clk);
    ps2d = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h1D, 1, 1, 0);
    check("after_glitch", {24'd0, in_port}, 32'h57);
    do_ack();

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 6);
      if (r <= 3) begin
        b = pick[$urandom_range(0, 6)];
        if (b == 8'h00) b = 8'($urandom_range(0, 255));
        send_frame(b, 1, 1, 0);
      end else if (r == 4) send_frame(8'($urandom_range(0, 255)), 0, 1, 0);
      else if (r == 5) send_frame(8'($urandom_range(0, 255)), 1, 0, 0);
      else do_ack();
    end

    send_partial(8'h1D, 5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_port", {24'd0, in_port}, 32'h00);
    check("mid_rst_interrupt", {31'd0, interrupt}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ferr_cnt = 0;
    repeat (TO + 20) @(negedge clk);
    check("mid_rst_no_ferr", ferr_cnt, 32'd0);
    send_frame(8'h1D, 1, 1, 1);
    check("post_rst_code", {24'd0, in_port}, 32'h57);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/teclado_irq.md
TECLADO_IRQ -- requirements
Module: teclado_irq

Interface
REQ-001 Parameter FILTER_LEN, default 8, number of consecutive equal ps2c samples required to accept a level change.
REQ-002 Parameter TIMEOUT_CYC, default 100000, idle clocks after which a partial frame is abandoned.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2c  input  1  PS/2 clock from keyboard, asynchronous.
REQ-006 ps2d  input  1  PS/2 data from keyboard, asynchronous.
REQ-007 interrupt_ack  input  1  processor acknowledge pulse; clears pending request.
REQ-008 in_port  output  8  held key code presented to the processor input port.
REQ-009 interrupt  output  1  level request, high while a key code is pending.
REQ-010 overflow  output  1  sticky: a mapped key arrived while one was pending.
REQ-011 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-012 ps2c and ps2d shall pass through 2-flop synchronizers before any use.
REQ-013 Synchronized ps2c shall be filtered: filtered level changes only after FILTER_LEN consecutive equal samples; a falling edge of the filtered clock is a bit strobe.
REQ-014 Frame FSM states IDLE, SHIFT, CHECK; IDLE->SHIFT on a strobe with ps2d=0 (start bit); strobe with ps2d=1 in IDLE is ignored.
REQ-015 SHIFT shall capture 8 data bits LSB first, then parity, then stop, on successive strobes (11 bits total incl. start), then go to CHECK.
REQ-016 CHECK shall accept the byte iff data+parity has odd ones count and stop=1; otherwise pulse frame_err one cycle and discard; always return to IDLE next cycle.
REQ-017 In SHIFT, TIMEOUT_CYC clocks with no strobe shall return FSM to IDLE, discard bits, pulse frame_err.
REQ-018 Accepted byte 0xF0 shall set a break flag; the next accepted byte is discarded and clears the flag.
REQ-019 Accepted byte 0xE0 shall set an extended flag; the next accepted byte is discarded and clears the flag; 0xE0 followed by 0xF0 discards the following byte too.
REQ-020 Make-code mapping: 0x1D->0x57 (W), 0x1B->0x53 (S), 0x1C->0x65 (A), 0x23->0x68 (D); all other make codes discarded silently.
REQ-021 Mapped key, no request pending: load in_port, assert interrupt on the cycle after CHECK (latency 1 clock from CHECK).
REQ-022 interrupt_ack high while interrupt high: deassert interrupt next cycle; in_port retains its value.
REQ-023 Mapped key while interrupt high and no ack that cycle: key dropped, in_port unchanged, overflow set.
REQ-024 Mapped key and interrupt_ack in the same cycle: new code loaded, interrupt remains high, overflow not set.
REQ-025 interrupt_ack while interrupt low shall have no effect.
REQ-026 overflow shall clear only on reset.

Reset
REQ-027 Reset shall force: frame FSM IDLE, bit counter 0, timeout counter 0, break/extended flags 0, filter to high level, synchronizers to 1, in_port=0x00, interrupt=0, overflow=0, frame_err=0.
REQ-028 Reset asserted mid-frame shall abandon the frame with no frame_err; first frame after release is received normally.

Structure
REQ-029 Shared package shall hold scan-code constants (0xF0, 0xE0, 0x1D, 0x1B, 0x1C, 0x23), key-code constants (0x57, 0x53, 0x65, 0x68), frame state encoding.
REQ-030 Filter, frame FSM and parity/stop check shall be one sub-module ps2_rx_frame (outputs byte, byte_valid pulse, frame_err); prefix handling, mapping and interrupt handshake stay in teclado_irq.

Verification
REQ-031 Frame 0x1D (parity 1, stop 1) -> in_port=0x57, interrupt=1 one clock after CHECK; ack pulse -> interrupt=0 next cycle, in_port still 0x57.
REQ-032 Frames F0,1D after a make -> no new interrupt, in_port unchanged; E0,1C -> discarded.
REQ-033 Frame 0x1B with parity 0 -> frame_err pulse 1 cycle, interrupt stays 0; stop=0 likewise.
REQ-034 0x1D then 0x1B without ack -> in_port=0x57, overflow=1; 0x1C arriving on the ack cycle -> in_port=0x65, interrupt stays 1.
REQ-035 Only 5 bits sent, then silence TIMEOUT_CYC clocks -> frame_err pulse, next full 0x23 frame -> in_port=0x68.
REQ-036 Glitch on ps2c shorter than FILTER_LEN clocks -> no strobe; reset mid-frame -> all outputs zero, next 0x1D frame received correctly.
